// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the fetch FSM state encoding, the default reset PC, the HLT opcode
// and the position of the opcode field inside an instruction word.
package fetch_stage_pkg;

    // Fetch FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // issue a request for pc
        ST_WAIT  = 2'd1,   // one request outstanding, awaiting the response
        ST_HOLD  = 2'd2,   // response captured while IF/ID was stalled
        ST_HALT  = 2'd3    // HLT delivered, no further requests
    } fetch_state_t;

    // PC value after reset.
    localparam logic [15:0] FETCH_RESET_PC    = 16'h0000;

    // instr[OPC_MSB:OPC_LSB] value that marks HLT.
    localparam logic [3:0]  FETCH_HALT_OPCODE = 4'hF;

    // Opcode field position inside an instruction word.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

endpackage

// File: rtl/fetch_hold_buf.sv
// Instruction + address register with load and clear, used both as the
// stall hold buffer and as the IF/ID-facing output register.
// Latency: 1 cycle from load/clear to outputs. Backpressure: holds when idle.
//
// Ports:
//   clk       - clock
//   rst       - synchronous reset, active low; contents <= 0
//   load      - capture {instr_in, pc_in}
//   clear     - zero the contents (wins over load)
//   instr_in  - instruction to capture
//   pc_in     - address of instr_in
//   instr     - stored instruction
//   pc        - stored address
module fetch_hold_buf #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    localparam int W = INSTR_W + ADDR_W;

    logic [W-1:0] d;
    logic [W-1:0] q;

    // Clear is just a load of zero, so one register serves both.
    assign d = clear ? '0 : {instr_in, pc_in};

    pldff #(
        .W       (W),
        .RST_VAL ('0)
    ) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (load | clear),
        .d   (d),
        .q   (q)
    );

    assign instr = q[W-1:ADDR_W];
    assign pc    = q[ADDR_W-1:0];

endmodule

// File: rtl/pldff.sv
// Generic parallel-load register with synchronous active-low reset.
// Latency: 1 cycle from en/d to q.
// Backpressure: none; q holds whenever en is low.
//
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous reset, active low; q <= RST_VAL
//   en   - load enable
//   d    - next value, captured when en=1
//   q    - registered value
module pldff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding request to
// variable-latency imem and delivers {instr, pc, pc+2} to IF/ID.
// Latency: response to IF/ID outputs 1 cycle; pc_wen=0 stalls (response parked in hold buffer).
//
// Ports:
//   clk           - clock, all state on posedge
//   rst           - synchronous reset, active low
//   pc_wen        - hazard unit PC write enable; 0 holds PC and outputs
//   redirect      - taken branch / flush; highest priority
//   redirect_pc   - branch target (bit 0 ignored)
//   imem_req      - one-cycle request pulse
//   imem_addr     - request address, valid while imem_req=1
//   imem_valid    - one-cycle response strobe
//   imem_data     - response instruction, valid with imem_valid
//   instr_out     - instruction to IF/ID
//   pc_out        - address of instr_out
//   pc_plus2_out  - pc_out + 2 (wraps)
//   instr_valid   - instr_out is a real instruction, not a bubble
//   halted        - HLT delivered, fetching stopped
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = FETCH_RESET_PC,
    parameter logic [3:0]        HALT_OPCODE = FETCH_HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_wen,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus2_out,
    output logic               instr_valid,
    output logic               halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    // Set when the outstanding request was overtaken by a redirect; its
    // response must be dropped when it eventually arrives.
    logic              squash;

    logic [ADDR_W-1:0] redirect_tgt;
    logic              resp_live;
    logic              deliver_live;
    logic              deliver_held;
    logic              deliver;
    logic              hold_load;
    logic              halt_hit;
    logic [INSTR_W-1:0] held_instr;
    logic [ADDR_W-1:0]  held_pc;
    logic [INSTR_W-1:0] deliver_instr;
    logic [ADDR_W-1:0]  deliver_pc;

    // Instructions are halfword aligned: bit 0 of the target is forced low.
    assign redirect_tgt = redirect_pc & ~ADDR_W'(1);

    // A response that belongs to the current pc (not squashed).
    assign resp_live    = (state == ST_WAIT) && imem_valid && !squash;

    // Redirect overrides everything, so no delivery or capture happens in
    // a redirect cycle.
    assign deliver_live = !redirect && resp_live && pc_wen;
    assign deliver_held = !redirect && (state == ST_HOLD) && pc_wen;
    assign deliver      = deliver_live || deliver_held;
    assign hold_load    = !redirect && resp_live && !pc_wen;

    assign deliver_instr = deliver_held ? held_instr : imem_data;
    assign deliver_pc    = deliver_held ? held_pc    : pc;
    assign halt_hit      = (deliver_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE);

    // Parks a response that arrived while IF/ID was stalled. A redirect
    // drops whatever is parked.
    fetch_hold_buf #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .clear    (redirect),
        .instr_in (imem_data),
        .pc_in    (pc),
        .instr    (held_instr),
        .pc       (held_pc)
    );

    // IF/ID-facing {instr, pc} register. Only changes on a delivery, so the
    // last instruction stays visible behind bubbles and stalls.
    fetch_hold_buf #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (deliver),
        .clear    (1'b0),
        .instr_in (deliver_instr),
        .pc_in    (deliver_pc),
        .instr    (instr_out),
        .pc       (pc_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            squash       <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= '0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            pc_plus2_out <= '0;
        end else begin
            imem_req <= 1'b0;

            if (deliver) begin
                pc_plus2_out <= deliver_pc + ADDR_W'(2);
            end

            if (redirect) begin
                pc          <= redirect_tgt;
                instr_valid <= 1'b0;
                halted      <= 1'b0;
                if ((state == ST_WAIT) && !imem_valid) begin
                    // Request still in flight: keep waiting for it so
                    // that only one is ever outstanding, but drop it.
                    squash <= 1'b1;
                end else begin
                    squash <= 1'b0;
                    state  <= ST_FETCH;
                end
            end else begin
                // With the pipeline advancing, a cycle without a delivery
                // becomes a bubble.
                if (pc_wen) begin
                    instr_valid <= deliver;
                end

                case (state)
                    ST_FETCH: begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (imem_valid) begin
                            squash <= 1'b0;
                            if (squash) begin
                                state <= ST_FETCH;
                            end else if (!pc_wen) begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Waits for pc_wen; delivery handled below.
                    end
                    ST_HALT: begin
                        // Only a redirect leaves HALT.
                    end
                    default: begin
                        state <= ST_FETCH;
                    end
                endcase

                // A delivered HLT is presented but freezes the PC on itself.
                if (deliver) begin
                    if (halt_hit) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        pc    <= pc + ADDR_W'(2);
                        state <= ST_FETCH;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stalls, redirects and memory latencies against a transaction-level model.
// Runs to a single summary line.
module tb_fetch_stage;

    localparam logic [15:0] NO_HALT = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wen;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2_out;
    logic        instr_valid;
    logic        halted;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .pc_wen       (pc_wen),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_plus2_out (pc_plus2_out),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Instruction memory: one pending response at a time.
    bit          mem_pend;
    int          mem_due;
    logic [15:0] mem_addr;
    int          lat;
    bit          rand_lat;
    logic [15:0] halt_addr;
    bit          inject;

    // Reference model: PC, whether a request is in flight / to be dropped,
    // a parked instruction, halt flag, and the expected registered outputs.
    logic [15:0] m_pc;
    bit          m_inflight;
    bit          m_stale;
    bit          m_halted;
    logic [15:0] m_held[$];
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_pc2;
    logic        e_valid;

    logic [15:0] req_log[$];
    logic [15:0] dlv_log[$];
    logic [15:0] dlv2_log[$];
    logic [15:0] instr_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        if (a == halt_addr) return 16'hF000;
        w = (a * 16'h9E37) ^ 16'h5A5A;
        if (w[15:12] == 4'hF) w[15:12] = 4'h7;
        return w;
    endfunction

    task automatic model_reset();
        m_pc       = 16'h0000;
        m_inflight = 1'b0;
        m_stale    = 1'b0;
        m_halted   = 1'b0;
        m_held.delete();
        e_req   = 1'b0;
        e_addr  = 16'h0000;
        e_instr = 16'h0000;
        e_pc    = 16'h0000;
        e_pc2   = 16'h0000;
        e_valid = 1'b0;
    endtask

    task automatic model_deliver(input logic [15:0] d);
        e_instr = d;
        e_pc    = m_pc;
        e_pc2   = m_pc + 16'd2;
        e_valid = 1'b1;
        if (d[15:12] == 4'hF) m_halted = 1'b1;
        else                  m_pc     = m_pc + 16'd2;
    endtask

    task automatic model_edge(input bit wen, input bit rd, input logic [15:0] rpc,
                              input bit v, input logic [15:0] d);
        bit resp;
        resp  = v && m_inflight;
        e_req = 1'b0;
        if (rd) begin
            m_pc     = {rpc[15:1], 1'b0};
            e_valid  = 1'b0;
            m_halted = 1'b0;
            m_held.delete();
            if (resp) begin
                m_inflight = 1'b0;
                m_stale    = 1'b0;
            end else if (m_inflight) begin
                m_stale = 1'b1;
            end
        end else if (m_halted) begin
            if (wen) e_valid = 1'b0;
        end else if (m_held.size() != 0) begin
            if (wen) begin
                model_deliver(m_held[0]);
                m_held.delete();
            end
        end else if (m_inflight) begin
            if (resp) begin
                m_inflight = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                    if (wen) e_valid = 1'b0;
                end else if (wen) begin
                    model_deliver(d);
                end else begin
                    m_held.push_back(d);
                end
            end else if (wen) begin
                e_valid = 1'b0;
            end
        end else begin
            e_req      = 1'b1;
            e_addr     = m_pc;
            m_inflight = 1'b1;
            if (wen) e_valid = 1'b0;
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        dlv_log.delete();
        dlv2_log.delete();
        instr_log.delete();
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 ns later.
    task automatic tick(input bit wen, input bit rd, input logic [15:0] rpc);
        bit          v;
        logic [15:0] d;
        v = 1'b0;
        d = 16'($urandom);
        if (inject) begin
            v      = 1'b1;
            d      = 16'h1234;
            inject = 1'b0;
        end else if (rst && mem_pend && cyc == mem_due) begin
            v        = 1'b1;
            d        = mem_word(mem_addr);
            mem_pend = 1'b0;
        end
        pc_wen      = wen;
        redirect    = rd;
        redirect_pc = rpc;
        imem_valid  = v;
        imem_data   = d;
        @(posedge clk);
        if (!rst) begin
            model_reset();
            mem_pend = 1'b0;
        end else begin
            model_edge(wen, rd, rpc, v, d);
        end
        #1;
        cyc++;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) chk("imem_addr", 32'(imem_addr), 32'(e_addr));
        chk("instr_valid", 32'(instr_valid), 32'(e_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("instr_out", 32'(instr_out), 32'(e_instr));
        chk("pc_out", 32'(pc_out), 32'(e_pc));
        chk("pc_plus2_out", 32'(pc_plus2_out), 32'(e_pc2));
        if (imem_req === 1'b1) begin
            chk("one_outstanding", 32'(mem_pend), 32'(0));
            req_log.push_back(imem_addr);
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            mem_due  = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
        end
        if (instr_valid === 1'b1) begin
            dlv_log.push_back(pc_out);
            dlv2_log.push_back(pc_plus2_out);
            instr_log.push_back(instr_out);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b1, 1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1'b1, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 16'h0000);
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (req_log.size() == 0 && k < 20) begin
            tick(1'b1, 1'b0, 16'h0000);
            k++;
        end
        chk(tag, 32'(req_log.size() != 0), 32'(1));
    endtask

    initial begin
        int  n0;
        int  k;
        int  stall;
        bit  stalled;
        bit  wen;
        bit  rd;
        logic [15:0] rpc;

        rst       = 1'b0;
        inject    = 1'b0;
        mem_pend  = 1'b0;
        rand_lat  = 1'b0;
        lat       = 1;
        halt_addr = NO_HALT;
        model_reset();

        // 1: latency 1, free-running.
        do_reset();
        run(14);
        chk("t1_req_count", 32'(req_log.size() >= 3), 32'(1));
        chk("t1_dlv_count", 32'(dlv_log.size() >= 3), 32'(1));
        if (req_log.size() >= 3 && dlv_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t1_addr", 32'(req_log[i]), 32'(2 * i));
                chk("t1_pc_out", 32'(dlv_log[i]), 32'(2 * i));
                chk("t1_pc_plus2", 32'(dlv2_log[i]), 32'(2 * i + 2));
            end
        end

        // 2: latency 3, stall two cycles on the response for pc 2.
        do_reset();
        lat     = 3;
        stall   = 0;
        stalled = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!stalled && mem_pend && cyc == mem_due && mem_addr == 16'h0002) begin
                stall   = 2;
                stalled = 1'b1;
            end
            tick(stall == 0, 1'b0, 16'h0000);
            if (stall > 0) stall--;
        end
        chk("t2_stall_hit", 32'(stalled), 32'(1));
        chk("t2_dlv_count", 32'(dlv_log.size() >= 2), 32'(1));
        if (dlv_log.size() >= 2) begin
            chk("t2_held_pc", 32'(dlv_log[1]), 32'(16'h0002));
            chk("t2_held_instr", 32'(instr_log[1]), 32'(mem_word(16'h0002)));
        end

        // 3: redirect while waiting; stale response dropped.
        do_reset();
        lat = 4;
        wait_req("t3_req_seen");
        tick(1'b1, 1'b1, 16'h0040);
        run(16);
        chk("t3_req_count", 32'(req_log.size() >= 2), 32'(1));
        if (req_log.size() >= 2) chk("t3_next_addr", 32'(req_log[1]), 32'(16'h0040));
        chk("t3_dlv_count", 32'(dlv_log.size() >= 1), 32'(1));
        if (dlv_log.size() >= 1) chk("t3_first_dlv", 32'(dlv_log[0]), 32'(16'h0040));

        // 4: redirect coincident with the response and with pc_wen=0.
        do_reset();
        lat = 2;
        k   = 0;
        while (!(mem_pend && cyc == mem_due) && k < 20) begin
            tick(1'b1, 1'b0, 16'h0000);
            k++;
        end
        chk("t4_resp_due", 32'(mem_pend && cyc == mem_due), 32'(1));
        tick(1'b0, 1'b1, 16'h0080);
        run(12);
        chk("t4_req_count", 32'(req_log.size() >= 2), 32'(1));
        if (req_log.size() >= 2) chk("t4_next_addr", 32'(req_log[1]), 32'(16'h0080));
        chk("t4_dlv_count", 32'(dlv_log.size() >= 1), 32'(1));
        if (dlv_log.size() >= 1) chk("t4_first_dlv", 32'(dlv_log[0]), 32'(16'h0080));

        // 5: HLT at pc 6, then redirect out of HALT.
        halt_addr = 16'h0006;
        do_reset();
        lat = 1;
        k   = 0;
        while (halted !== 1'b1 && k < 40) begin
            tick(1'b1, 1'b0, 16'h0000);
            k++;
        end
        chk("t5_halted", 32'(halted), 32'(1));
        chk("t5_halt_valid", 32'(instr_valid), 32'(1));
        chk("t5_halt_pc", 32'(pc_out), 32'(16'h0006));
        chk("t5_halt_instr", 32'(instr_out), 32'(16'hF000));
        n0 = req_log.size();
        run(10);
        chk("t5_no_req", 32'(req_log.size() - n0), 32'(0));
        tick(1'b1, 1'b1, 16'h0010);
        chk("t5_unhalt", 32'(halted), 32'(0));
        n0 = req_log.size();
        run(8);
        chk("t5_req_after", 32'(req_log.size() > n0), 32'(1));
        if (req_log.size() > n0) chk("t5_resume_addr", 32'(req_log[n0]), 32'(16'h0010));
        halt_addr = NO_HALT;

        // 6: reset mid-request, stale strobe right after release.
        do_reset();
        lat = 4;
        wait_req("t6_req_seen");
        tick(1'b1, 1'b0, 16'h0000);
        rst = 1'b0;
        tick(1'b1, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 16'h0000);
        rst = 1'b1;
        clear_logs();
        inject = 1'b1;
        run(14);
        chk("t6_dlv_count", 32'(dlv_log.size() >= 1), 32'(1));
        if (req_log.size() >= 1) chk("t6_first_addr", 32'(req_log[0]), 32'(16'h0000));
        if (dlv_log.size() >= 1) begin
            chk("t6_first_pc", 32'(dlv_log[0]), 32'(16'h0000));
            chk("t6_first_instr", 32'(instr_log[0]), 32'(mem_word(16'h0000)));
        end

        // Wrap: odd target forced even, FFFE + 2 wraps to 0000.
        lat = 1;
        clear_logs();
        tick(1'b1, 1'b1, 16'hFFFF);
        run(12);
        chk("wrap_req_count", 32'(req_log.size() >= 2), 32'(1));
        if (req_log.size() >= 2) begin
            chk("wrap_addr0", 32'(req_log[0]), 32'(16'hFFFE));
            chk("wrap_addr1", 32'(req_log[1]), 32'(16'h0000));
        end
        chk("wrap_dlv_count", 32'(dlv_log.size() >= 1), 32'(1));
        if (dlv_log.size() >= 1) begin
            chk("wrap_pc_out", 32'(dlv_log[0]), 32'(16'hFFFE));
            chk("wrap_pc_plus2", 32'(dlv2_log[0]), 32'(16'h0000));
        end

        // Randomized stalls, redirects, latencies and occasional HLT.
        halt_addr = 16'h0020;
        rand_lat  = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wen = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            tick(wen, rd, rpc);
        end
        halt_addr = NO_HALT;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
